// File: rtl/wb_pipe_stage_pkg.sv
// rtl/wb_pipe_stage_pkg.sv - shared control-bit indices, state encoding and default widths for the MEM->WB stage
package wb_pipe_stage_pkg;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_W   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_entry_reg.sv
// rtl/wb_entry_reg.sv - one pipeline entry (ctrl/mem_data/alu_result/rd) with load and clear
module wb_entry_reg import wb_pipe_stage_pkg::*; #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [RD_W-1:0]   i_rd,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_mem_data,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [RD_W-1:0]   o_rd
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_alu_result;
    logic [RD_W-1:0]   r_rd;

    // Clear wins over load so an emptied slot always reads as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl       <= '0;
            r_mem_data   <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
        end else if (i_clear) begin
            r_ctrl       <= '0;
            r_mem_data   <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
        end else if (i_load) begin
            r_ctrl       <= i_ctrl;
            r_mem_data   <= i_mem_data;
            r_alu_result <= i_alu_result;
            r_rd         <= i_rd;
        end
    end

    assign o_ctrl       = r_ctrl;
    assign o_mem_data   = r_mem_data;
    assign o_alu_result = r_alu_result;
    assign o_rd         = r_rd;

endmodule

// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - MEM->WB pipeline stage with valid/ready handshake, optional skid entry and flush
module wb_pipe_stage import wb_pipe_stage_pkg::*; #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write_enable,
    output logic [1:0]        occupancy
);

    wb_state_t r_state;
    wb_state_t w_state_nxt;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_main_load;
    logic w_main_clear;
    logic w_main_from_skid;
    logic w_skid_load;
    logic w_skid_clear;

    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_mem_data;
    logic [DATA_W-1:0] w_skid_alu_result;
    logic [RD_W-1:0]   w_skid_rd;

    logic [CTRL_W-1:0] w_main_d_ctrl;
    logic [DATA_W-1:0] w_main_d_mem_data;
    logic [DATA_W-1:0] w_main_d_alu_result;
    logic [RD_W-1:0]   w_main_d_rd;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ONE;
                        w_main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        w_state_nxt = FULL;
                        w_skid_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt  = EMPTY;
                        w_main_clear = 1'b1;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // Head refills from the skid slot when draining FULL, otherwise straight from MEM.
    assign w_main_d_ctrl       = w_main_from_skid ? w_skid_ctrl       : in_ctrl;
    assign w_main_d_mem_data   = w_main_from_skid ? w_skid_mem_data   : in_mem_data;
    assign w_main_d_alu_result = w_main_from_skid ? w_skid_alu_result : in_alu_result;
    assign w_main_d_rd         = w_main_from_skid ? w_skid_rd         : in_rd;

    wb_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_main_load),
        .i_clear      (w_main_clear),
        .i_ctrl       (w_main_d_ctrl),
        .i_mem_data   (w_main_d_mem_data),
        .i_alu_result (w_main_d_alu_result),
        .i_rd         (w_main_d_rd),
        .o_ctrl       (out_ctrl),
        .o_mem_data   (out_mem_data),
        .o_alu_result (out_alu_result),
        .o_rd         (out_rd)
    );

    generate
        if (SKID != 0) begin : g_skid
            wb_entry_reg #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .RD_W   (RD_W)
            ) u_skid (
                .clk          (clk),
                .reset        (reset),
                .i_load       (w_skid_load),
                .i_clear      (w_skid_clear),
                .i_ctrl       (in_ctrl),
                .i_mem_data   (in_mem_data),
                .i_alu_result (in_alu_result),
                .i_rd         (in_rd),
                .o_ctrl       (w_skid_ctrl),
                .o_mem_data   (w_skid_mem_data),
                .o_alu_result (w_skid_alu_result),
                .o_rd         (w_skid_rd)
            );
            // Ready comes from registered state only, cutting the path from out_ready.
            assign in_ready = (r_state != FULL) & ~flush;
        end else begin : g_no_skid
            logic w_unused_skid;
            assign w_unused_skid     = w_skid_load | w_skid_clear;
            assign w_skid_ctrl       = '0;
            assign w_skid_mem_data   = '0;
            assign w_skid_alu_result = '0;
            assign w_skid_rd         = '0;
            assign in_ready          = (~out_valid | out_ready) & ~flush;
        end
    endgenerate

    assign out_valid            = (r_state != EMPTY);
    assign out_reg_write_enable = out_valid & out_ctrl[CTRL_REG_WRITE];
    assign occupancy            = r_state;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - directed self-checking bench for wb_pipe_stage (SKID=1 and SKID=0 builds)
module tb_wb_pipe_stage;

    logic        clk;
    logic        reset;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_we;
    logic [1:0]  in_ctrl, out_ctrl, occupancy;
    logic [31:0] in_mem_data, in_alu_result, out_mem_data, out_alu_result;
    logic [3:0]  in_rd, out_rd;

    logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_out_we;
    logic [1:0]  z_in_ctrl, z_out_ctrl, z_occupancy;
    logic [31:0] z_in_mem_data, z_in_alu_result, z_out_mem_data, z_out_alu_result;
    logic [3:0]  z_in_rd, z_out_rd;

    int checks = 0;
    int errors = 0;

    wb_pipe_stage #(.CTRL_W(2), .DATA_W(32), .RD_W(4), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_mem_data(in_mem_data), .in_alu_result(in_alu_result), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_mem_data(out_mem_data), .out_alu_result(out_alu_result), .out_rd(out_rd),
        .out_reg_write_enable(out_we), .occupancy(occupancy)
    );

    wb_pipe_stage #(.CTRL_W(2), .DATA_W(32), .RD_W(4), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(z_flush),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl),
        .in_mem_data(z_in_mem_data), .in_alu_result(z_in_alu_result), .in_rd(z_in_rd),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl),
        .out_mem_data(z_out_mem_data), .out_alu_result(z_out_alu_result), .out_rd(z_out_rd),
        .out_reg_write_enable(z_out_we), .occupancy(z_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] c, input logic [31:0] alu, input logic [3:0] rd);
        in_valid      = 1'b1;
        in_ctrl       = c;
        in_alu_result = alu;
        in_mem_data   = ~alu;
        in_rd         = rd;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_mem_data = '0; in_alu_result = '0; in_rd = '0;
        z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0;
        z_in_ctrl = '0; z_in_mem_data = '0; z_in_alu_result = '0; z_in_rd = '0;

        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_out_ctrl",  {30'd0, out_ctrl}, 32'd0);
        chk("rst_out_alu",   out_alu_result, 32'd0);
        chk("rst_out_rd",    {28'd0, out_rd}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // single entry
        out_ready = 1'b1;
        offer(2'b01, 32'h0000_00A5, 4'd3);
        step();
        in_valid = 1'b0;
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_alu",   out_alu_result, 32'h0000_00A5);
        chk("single_mem",   out_mem_data, 32'hFFFF_FF5A);
        chk("single_rd",    {28'd0, out_rd}, 32'd3);
        chk("single_we",    {31'd0, out_we}, 32'd1);
        chk("single_occ",   {30'd0, occupancy}, 32'd1);
        step();
        chk("single_drain_valid", {31'd0, out_valid}, 32'd0);
        chk("single_drain_ctrl",  {30'd0, out_ctrl}, 32'd0);
        chk("single_drain_occ",   {30'd0, occupancy}, 32'd0);

        // mem-to-reg only: valid but no write strobe
        offer(2'b10, 32'h0000_0077, 4'd9);
        step();
        in_valid = 1'b0;
        chk("m2r_ctrl", {30'd0, out_ctrl}, 32'd2);
        chk("m2r_we",   {31'd0, out_we}, 32'd0);
        step();

        // backpressure fill
        out_ready = 1'b0;
        offer(2'b01, 32'h11, 4'd1);
        step();
        chk("bp_one_ready", {31'd0, in_ready}, 32'd1);
        offer(2'b01, 32'h22, 4'd2);
        step();
        in_valid = 1'b0;
        chk("bp_full_occ",   {30'd0, occupancy}, 32'd2);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_head",  out_alu_result, 32'h11);
        step();
        chk("bp_hold_head",  out_alu_result, 32'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_no_comb", {31'd0, in_ready}, 32'd0);
        step();
        chk("bp_second_alu", out_alu_result, 32'h22);
        chk("bp_second_rd",  {28'd0, out_rd}, 32'd2);
        chk("bp_second_occ", {30'd0, occupancy}, 32'd1);
        step();
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

        // streaming
        for (int i = 1; i <= 8; i++) begin
            offer(2'b01, i, 4'(i));
            step();
            chk("stream_alu",   out_alu_result, i);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_occ",   {30'd0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // flush while FULL with a concurrent offer
        out_ready = 1'b0;
        offer(2'b01, 32'h33, 4'd4);
        step();
        offer(2'b01, 32'h44, 4'd5);
        step();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        flush = 1'b1;
        offer(2'b01, 32'h55, 4'd6);
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_occ",   {30'd0, occupancy}, 32'd0);
        chk("fl_we",    {31'd0, out_we}, 32'd0);
        chk("fl_ctrl",  {30'd0, out_ctrl}, 32'd0);
        step();
        chk("fl_dropped", {31'd0, out_valid}, 32'd0);

        // async reset while FULL
        offer(2'b01, 32'h66, 4'd7);
        step();
        offer(2'b01, 32'h77, 4'd8);
        step();
        in_valid = 1'b0;
        chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_alu",   out_alu_result, 32'd0);
        chk("ar_occ",   {30'd0, occupancy}, 32'd0);
        chk("ar_we",    {31'd0, out_we}, 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_post_occ", {30'd0, occupancy}, 32'd0);
        step();

        // SKID=0 build
        z_out_ready = 1'b0;
        z_in_valid = 1'b1; z_in_ctrl = 2'b01; z_in_alu_result = 32'hAA; z_in_rd = 4'd10;
        step();
        chk("s0_valid",    {31'd0, z_out_valid}, 32'd1);
        chk("s0_in_ready", {31'd0, z_in_ready}, 32'd0);
        chk("s0_occ",      {30'd0, z_occupancy}, 32'd1);
        z_in_alu_result = 32'hBB; z_in_rd = 4'd11;
        step();
        chk("s0_stable",   z_out_alu_result, 32'hAA);
        chk("s0_occ_max",  {30'd0, z_occupancy}, 32'd1);
        z_out_ready = 1'b1;
        #1;
        chk("s0_comb_ready", {31'd0, z_in_ready}, 32'd1);
        step();
        chk("s0_replace_alu", z_out_alu_result, 32'hBB);
        chk("s0_replace_rd",  {28'd0, z_out_rd}, 32'd11);
        chk("s0_replace_occ", {30'd0, z_occupancy}, 32'd1);
        z_in_valid = 1'b0;
        step();
        chk("s0_empty", {31'd0, z_out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
